// File: rtl/peg_pkt_xfr_fifo.sv
// Packet FIFO with framing check, registered show-ahead egress and optional store-and-forward.
// Storage holds {sop,eop,data}; fill_lvl and pkt_cnt include the word parked in the egress register.
module peg_pkt_xfr_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int SAF_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ingr_sop,
  input  logic                     ingr_eop,
  input  logic                     ingr_valid,
  input  logic [DATA_W-1:0]        ingr_data,
  output logic                     ingr_ready,
  output logic                     egr_sop,
  output logic                     egr_eop,
  output logic                     egr_valid,
  output logic [DATA_W-1:0]        egr_data,
  input  logic                     egr_ready,
  output logic [$clog2(DEPTH):0]   fill_lvl,
  output logic [$clog2(DEPTH):0]   pkt_cnt,
  output logic                     frm_err,
  output logic                     ovsz_err
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WORD_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic {FRM_IDLE = 1'b0, FRM_IN_PKT = 1'b1} frm_state_e;

  logic [WORD_W-1:0] mem [DEPTH];

  frm_state_e        frm_q, frm_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d, pkt_q, pkt_d, mem_pkt_q, mem_pkt_d;
  logic              head_part_q, head_part_d, alive_q;
  logic              egr_valid_q, egr_valid_d, egr_sop_q, egr_sop_d, egr_eop_q, egr_eop_d;
  logic [DATA_W-1:0] egr_data_q, egr_data_d;
  logic              frm_err_q, frm_err_d, ovsz_q, ovsz_d;

  logic              acc_s, wr_s, disc_s, egr_hs_s, elig_s, load_s, ovsz_hit_s;
  logic [CNT_W-1:0]  mem_cnt_s;
  logic [WORD_W-1:0] head_s;

  assign ingr_ready = alive_q && (fill_q != FULL_LVL);
  assign head_s     = mem[rd_ptr_q];
  assign egr_valid  = egr_valid_q;
  assign egr_sop    = egr_sop_q;
  assign egr_eop    = egr_eop_q;
  assign egr_data   = egr_data_q;
  assign fill_lvl   = fill_q;
  assign pkt_cnt    = pkt_q;
  assign frm_err    = frm_err_q;
  assign ovsz_err   = ovsz_q;

  // Ingress framing: decide whether an accepted word is stored or discarded
  always_comb begin
    acc_s  = ingr_valid && ingr_ready;
    frm_d  = frm_q;
    wr_s   = 1'b0;
    disc_s = 1'b0;
    if (acc_s) begin
      case (frm_q)
        FRM_IDLE: begin
          if (ingr_sop) begin
            wr_s  = 1'b1;
            frm_d = ingr_eop ? FRM_IDLE : FRM_IN_PKT;
          end else begin
            disc_s = 1'b1;
          end
        end
        FRM_IN_PKT: begin
          if (ingr_sop) begin
            disc_s = 1'b1;
          end else begin
            wr_s  = 1'b1;
            frm_d = ingr_eop ? FRM_IDLE : FRM_IN_PKT;
          end
        end
        default: frm_d = FRM_IDLE;
      endcase
    end else begin
      frm_d = frm_q;
    end
  end

  // Egress eligibility, egress register load and counter updates
  always_comb begin
    egr_hs_s   = egr_valid_q && egr_ready;
    mem_cnt_s  = fill_q - CNT_W'(egr_valid_q);
    // A full buffer with no complete packet can never finish in SAF mode: push it out cut-through
    ovsz_hit_s = (SAF_EN != 0) && (fill_q == FULL_LVL) && (pkt_q == CNT_ZERO);
    elig_s     = (mem_cnt_s != CNT_ZERO) &&
                 ((SAF_EN == 0) || (mem_pkt_q != CNT_ZERO) || head_part_q || ovsz_hit_s);
    load_s     = elig_s && (!egr_valid_q || egr_ready);

    egr_valid_d = egr_valid_q;
    egr_sop_d   = egr_sop_q;
    egr_eop_d   = egr_eop_q;
    egr_data_d  = egr_data_q;
    head_part_d = head_part_q;
    if (load_s) begin
      egr_valid_d = 1'b1;
      egr_sop_d   = head_s[DATA_W+1];
      egr_eop_d   = head_s[DATA_W];
      egr_data_d  = head_s[DATA_W-1:0];
      head_part_d = !head_s[DATA_W];
    end else if (egr_hs_s) begin
      egr_valid_d = 1'b0;
    end else begin
      egr_valid_d = egr_valid_q;
    end

    wr_ptr_d  = wr_s   ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = load_s ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    fill_d    = fill_q + CNT_W'(wr_s) - CNT_W'(egr_hs_s);
    pkt_d     = pkt_q + CNT_W'(wr_s && ingr_eop) - CNT_W'(egr_hs_s && egr_eop_q);
    mem_pkt_d = mem_pkt_q + CNT_W'(wr_s && ingr_eop) - CNT_W'(load_s && head_s[DATA_W]);
    frm_err_d = disc_s;
    ovsz_d    = ovsz_q || ovsz_hit_s;
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem[wr_ptr_q] <= {ingr_sop, ingr_eop, ingr_data};
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q       <= FRM_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      pkt_q       <= '0;
      mem_pkt_q   <= '0;
      head_part_q <= 1'b0;
      alive_q     <= 1'b0;
      egr_valid_q <= 1'b0;
      egr_sop_q   <= 1'b0;
      egr_eop_q   <= 1'b0;
      egr_data_q  <= '0;
      frm_err_q   <= 1'b0;
      ovsz_q      <= 1'b0;
    end else begin
      frm_q       <= frm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      pkt_q       <= pkt_d;
      mem_pkt_q   <= mem_pkt_d;
      head_part_q <= head_part_d;
      alive_q     <= 1'b1;
      egr_valid_q <= egr_valid_d;
      egr_sop_q   <= egr_sop_d;
      egr_eop_q   <= egr_eop_d;
      egr_data_q  <= egr_data_d;
      frm_err_q   <= frm_err_d;
      ovsz_q      <= ovsz_d;
    end
  end
endmodule
